// File: rtl/sdr_pkg.sv
// ----------------------------------------------------------------------------
// sdr_pkg
// Shared definitions for the SDR receive chain (NCO, mixer, CIC decimator).
//  - Default decimation ratio, stage count, comb delay and sample width used
//    by the top level and by the CIC decimator.
//  - clog2 helper plus the CIC register-growth and accumulator-width rules.
// No ports (package).
// ----------------------------------------------------------------------------
package sdr_pkg;

    localparam int DEF_IN_W       = 32'sd16;
    localparam int DEF_STAGES     = 32'sd3;
    localparam int DEF_DECIM      = 32'sd64;
    localparam int DEF_DIFF_DELAY = 32'sd1;

    // Ceiling log2; returns 0 for values of 1 or less.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 32'sd0;
        rem    = value - 32'sd1;
        while (rem > 32'sd0) begin
            result = result + 32'sd1;
            rem    = rem >>> 1;
        end
        return result;
    endfunction

    // Worst-case bit growth of an N-stage CIC with ratio R and delay M:
    // N * log2(R*M). R is a power of two and M is 1 or 2, so this is exact.
    function automatic int cic_growth(input int stages, input int decim, input int diff_delay);
        return stages * clog2(decim * diff_delay);
    endfunction

    // Accumulator width that makes the integrator wrap-around harmless.
    function automatic int cic_acc_w(input int in_w, input int stages, input int decim,
                                     input int diff_delay);
        return in_w + cic_growth(stages, decim, diff_delay);
    endfunction

endpackage

// File: rtl/cic_channel.sv
// ----------------------------------------------------------------------------
// cic_channel
// One channel of the CIC decimator: an integrator chain running at the input
// rate followed by a comb chain running at the decimated rate. All arithmetic
// is ACC_W-bit two's complement and wraps; the wrap cancels in the combs.
// Ports:
//  clk       in   1       clock, rising edge
//  reset     in   1       synchronous active-high reset
//  in_valid  in   1       integrators update only when high
//  capture   in   1       load last integrator into the comb input register
//  comb_en   in   STAGES  per-stage comb strobes (pipelined by the parent)
//  din       in   IN_W    signed input sample
//  dout      out  ACC_W   signed output of the last comb stage
// ----------------------------------------------------------------------------
module cic_channel
    import sdr_pkg::*;
#(
    parameter int IN_W       = DEF_IN_W,
    parameter int STAGES     = DEF_STAGES,
    parameter int DIFF_DELAY = DEF_DIFF_DELAY,
    parameter int ACC_W      = cic_acc_w(DEF_IN_W, DEF_STAGES, DEF_DECIM, DEF_DIFF_DELAY)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic                    capture,
    input  logic [STAGES-1:0]       comb_en,
    input  logic signed [IN_W-1:0]  din,
    output logic signed [ACC_W-1:0] dout
);

    logic signed [ACC_W-1:0] din_ext_s;
    logic signed [ACC_W-1:0] integ_r   [STAGES];
    logic signed [ACC_W-1:0] comb_in_r;
    logic signed [ACC_W-1:0] comb_x_s  [STAGES];
    logic signed [ACC_W-1:0] comb_r    [STAGES];
    logic signed [ACC_W-1:0] delay_r   [STAGES][DIFF_DELAY];

    assign din_ext_s = {{(ACC_W-IN_W){din[IN_W-1]}}, din};

    // Integrator chain: each stage adds the previous stage's registered value.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                integ_r[k] <= '0;
            end
        end else if (in_valid) begin
            integ_r[0] <= integ_r[0] + din_ext_s;
            for (int k = 1; k < STAGES; k++) begin
                integ_r[k] <= integ_r[k] + integ_r[k-1];
            end
        end
    end

    // Comb input register: snapshot of the last integrator on the decimating sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            comb_in_r <= '0;
        end else if (capture) begin
            comb_in_r <= integ_r[STAGES-1];
        end
    end

    // Comb stage inputs: stage 0 reads the snapshot, stage k reads comb k-1.
    always_comb begin
        comb_x_s[0] = comb_in_r;
        for (int k = 1; k < STAGES; k++) begin
            comb_x_s[k] = comb_r[k-1];
        end
    end

    // Comb chain: y = x - x delayed by DIFF_DELAY comb samples, on each stage strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                comb_r[k] <= '0;
                for (int d = 0; d < DIFF_DELAY; d++) begin
                    delay_r[k][d] <= '0;
                end
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (comb_en[k]) begin
                    comb_r[k]     <= comb_x_s[k] - delay_r[k][DIFF_DELAY-1];
                    delay_r[k][0] <= comb_x_s[k];
                    for (int d = 1; d < DIFF_DELAY; d++) begin
                        delay_r[k][d] <= delay_r[k][d-1];
                    end
                end
            end
        end
    end

    assign dout = comb_r[STAGES-1];

endmodule

// File: rtl/cic_iq_decimator.sv
// ----------------------------------------------------------------------------
// cic_iq_decimator
// Dual-channel (I/Q) CIC decimator behind the mixer. Decimates by DECIM with
// unity DC gain: the (R*M)^N CIC gain is removed by keeping the top OUT_W bits
// of the ACC_W-bit comb output (truncation).
// Ports:
//  clk       in   1      clock, rising edge
//  reset     in   1      synchronous active-high reset
//  in_valid  in   1      input sample strobe
//  sin_i     in   IN_W   signed I-channel sample
//  cos_i     in   IN_W   signed Q-channel sample
//  i_o       out  OUT_W  signed decimated I output (holds between pulses)
//  q_o       out  OUT_W  signed decimated Q output (holds between pulses)
//  out_valid out  1      one-cycle pulse marking a new i_o/q_o pair
// The decimation counter, the comb strobe pipeline and the output registers
// are shared by both channels so I and Q stay cycle-aligned and bit-exact.
// ----------------------------------------------------------------------------
module cic_iq_decimator
    import sdr_pkg::*;
#(
    parameter int IN_W       = DEF_IN_W,
    parameter int OUT_W      = DEF_IN_W,
    parameter int STAGES     = DEF_STAGES,
    parameter int DECIM      = DEF_DECIM,
    parameter int DIFF_DELAY = DEF_DIFF_DELAY
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic signed [IN_W-1:0]  sin_i,
    input  logic signed [IN_W-1:0]  cos_i,
    output logic signed [OUT_W-1:0] i_o,
    output logic signed [OUT_W-1:0] q_o,
    output logic                    out_valid
);

    localparam int ACC_W = cic_acc_w(IN_W, STAGES, DECIM, DIFF_DELAY);
    localparam int CNT_W = clog2(DECIM);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

    logic [CNT_W-1:0]        cnt_r;
    logic                    decim_s;
    // strobe_r[k] enables comb stage k; strobe_r[STAGES] loads the outputs.
    logic [STAGES:0]         strobe_r;
    logic signed [ACC_W-1:0] i_acc_s;
    logic signed [ACC_W-1:0] q_acc_s;

    assign decim_s = in_valid && (cnt_r == CNT_LAST);

    // Decimation counter: counts accepted samples modulo DECIM.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (in_valid) begin
            cnt_r <= decim_s ? {CNT_W{1'b0}} : cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Strobe pipeline: one bit per comb stage, so back-to-back decimating
    // samples (DECIM=2) each walk through the combs independently.
    always_ff @(posedge clk) begin
        if (reset) begin
            strobe_r <= '0;
        end else begin
            strobe_r <= {strobe_r[STAGES-1:0], decim_s};
        end
    end

    cic_channel #(
        .IN_W       (IN_W),
        .STAGES     (STAGES),
        .DIFF_DELAY (DIFF_DELAY),
        .ACC_W      (ACC_W)
    ) u_chan_i (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .capture  (decim_s),
        .comb_en  (strobe_r[STAGES-1:0]),
        .din      (sin_i),
        .dout     (i_acc_s)
    );

    cic_channel #(
        .IN_W       (IN_W),
        .STAGES     (STAGES),
        .DIFF_DELAY (DIFF_DELAY),
        .ACC_W      (ACC_W)
    ) u_chan_q (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .capture  (decim_s),
        .comb_en  (strobe_r[STAGES-1:0]),
        .din      (cos_i),
        .dout     (q_acc_s)
    );

    // Output register: top OUT_W bits of the comb result divide out the CIC gain.
    always_ff @(posedge clk) begin
        if (reset) begin
            i_o       <= '0;
            q_o       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= strobe_r[STAGES];
            if (strobe_r[STAGES]) begin
                i_o <= i_acc_s[ACC_W-1 -: OUT_W];
                q_o <= q_acc_s[ACC_W-1 -: OUT_W];
            end
        end
    end

endmodule

// File: tb/tb_cic_iq_decimator.sv
// ----------------------------------------------------------------------------
// tb_cic_iq_decimator
// Directed bench for cic_iq_decimator at default parameters (N=3, R=64, M=1).
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// ----------------------------------------------------------------------------
module tb_cic_iq_decimator;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic signed [15:0] sin_i;
    logic signed [15:0] cos_i;
    logic signed [15:0] i_o;
    logic signed [15:0] q_o;
    logic               out_valid;

    int  checks   = 0;
    int  errors   = 0;
    int  mode     = 0;     // 0 static, 1 gapped toggle, 2 cosine tone on I
    int  tone_n   = 0;
    int  tone_per = 4096;
    real tone_v;

    always #5 clk = ~clk;

    cic_iq_decimator dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .sin_i     (sin_i),
        .cos_i     (cos_i),
        .i_o       (i_o),
        .q_o       (q_o),
        .out_valid (out_valid)
    );

    task automatic check_value(input string tag, input logic signed [31:0] got,
                               input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock edge, then drive the next stimulus for the chosen mode.
    task automatic tick();
        @(posedge clk);
        #1;
        case (mode)
            1: begin
                in_valid = ~in_valid;
                sin_i    = in_valid ? 16'sd500  : 16'sd7777;
                cos_i    = in_valid ? -16'sd500 : 16'sd1234;
            end
            2: begin
                tone_v = 8000.0 * $cos(2.0 * 3.14159265358979 * real'(tone_n) / real'(tone_per));
                sin_i  = 16'($rtoi(tone_v >= 0.0 ? tone_v + 0.5 : tone_v - 0.5));
                cos_i  = 16'sd0;
                tone_n++;
            end
            default: begin
            end
        endcase
    endtask

    task automatic do_reset();
        mode     = 0;
        reset    = 1'b1;
        in_valid = 1'b0;
        sin_i    = 16'sd0;
        cos_i    = 16'sd0;
        tick();
        tick();
        reset    = 1'b0;
    endtask

    // Count edges until out_valid is seen; a missed pulse is a failed comparison.
    task automatic wait_pulse(input string tag, input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!out_valid && n < limit);
        if (!out_valid) check_value({tag, "_timeout"}, 32'(out_valid), 32'sd1);
    endtask

    task automatic skip_pulses(input int count, input int limit);
        int n;
        for (int p = 0; p < count; p++) wait_pulse("skip", limit, n);
    endtask

    initial begin
        int n;
        int amp;
        int qamp;
        int v;

        // Reset state
        reset    = 1'b1;
        in_valid = 1'b0;
        sin_i    = 16'sd0;
        cos_i    = 16'sd0;
        tick(); tick(); tick();
        check_value("rst_i", i_o, 32'sd0);
        check_value("rst_q", q_o, 32'sd0);
        check_value("rst_valid", 32'(out_valid), 32'sd0);

        // DC and latency: first pulse at edge 68 after release, then every 64
        reset    = 1'b0;
        in_valid = 1'b1;
        sin_i    = 16'sd1000;
        cos_i    = -16'sd1000;
        wait_pulse("lat", 200, n);
        check_value("first_latency", n, 32'sd68);
        wait_pulse("per", 200, n);
        check_value("dc_period", n, 32'sd64);
        skip_pulses(3, 200);
        check_value("dc_i", i_o, 32'sd1000);
        check_value("dc_q", q_o, -32'sd1000);
        tick();
        check_value("pulse_width", 32'(out_valid), 32'sd0);
        for (int c = 0; c < 9; c++) tick();
        check_value("hold_i", i_o, 32'sd1000);
        check_value("hold_q", q_o, -32'sd1000);
        wait_pulse("per2", 200, n);
        check_value("dc_period2", n, 32'sd54);
        check_value("dc_i_6", i_o, 32'sd1000);

        // Reset 3 cycles after a decimating sample: in-flight pulse is dropped
        for (int c = 0; c < 62; c++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_value("midrst_i", i_o, 32'sd0);
        check_value("midrst_q", q_o, 32'sd0);
        check_value("midrst_valid", 32'(out_valid), 32'sd0);
        wait_pulse("midrst", 200, n);
        check_value("midrst_latency", n, 32'sd68);

        // Full scale, both polarities, integrators wrap
        do_reset();
        in_valid = 1'b1;
        sin_i    = -16'sd32768;
        cos_i    = 16'sd32767;
        skip_pulses(6, 200);
        check_value("fs_neg_i", i_o, -32'sd32768);
        check_value("fs_pos_q", q_o, 32'sd32767);
        do_reset();
        in_valid = 1'b1;
        sin_i    = 16'sd32767;
        cos_i    = -16'sd32768;
        skip_pulses(6, 200);
        check_value("fs_pos_i", i_o, 32'sd32767);
        check_value("fs_neg_q", q_o, -32'sd32768);

        // Gapped input: garbage on idle cycles must not reach the integrators
        do_reset();
        in_valid = 1'b0;
        sin_i    = 16'sd7777;
        cos_i    = 16'sd1234;
        mode     = 1;
        wait_pulse("gap_first", 400, n);
        wait_pulse("gap_per", 400, n);
        check_value("gap_period", n, 32'sd128);
        skip_pulses(4, 400);
        check_value("gap_i", i_o, 32'sd500);
        check_value("gap_q", q_o, -32'sd500);

        // Passband tone at fs/4096: amplitude within 1% of 8000
        do_reset();
        in_valid = 1'b1;
        tone_per = 4096;
        tone_n   = 0;
        mode     = 2;
        skip_pulses(6, 200);
        amp  = 0;
        qamp = 0;
        for (int p = 0; p < 66; p++) begin
            wait_pulse("tone", 200, n);
            v = i_o;
            if (v < 0) v = -v;
            if (v > amp) amp = v;
            v = q_o;
            if (v < 0) v = -v;
            if (v > qamp) qamp = v;
        end
        check_value("tone_amp_in_1pct", 32'((amp >= 7920) && (amp <= 8080)), 32'sd1);
        check_value("tone_q_zero", qamp, 32'sd0);

        // Tone at fs/64 sits on a CIC null
        do_reset();
        in_valid = 1'b1;
        tone_per = 64;
        tone_n   = 0;
        mode     = 2;
        skip_pulses(6, 200);
        amp = 0;
        for (int p = 0; p < 8; p++) begin
            wait_pulse("null", 200, n);
            v = i_o;
            if (v < 0) v = -v;
            if (v > amp) amp = v;
        end
        check_value("alias_null_lt8", 32'(amp < 8), 32'sd1);
        mode = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
